disp_timing_gen: RTL



---
 rtl/disp_timing_pkg.sv | 26 ++
 rtl/disp_delay_line.sv | 41 ++++
 rtl/disp_timing_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/disp_timing_pkg.sv
// Shared timing constants, phase encoding and total-count helper for the
// display timing generator.
package disp_timing_pkg;

    localparam int CNT_W     = 11;
    localparam int MAX_TOTAL = 2048;

    // 640x480@60 defaults
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_OUT_DLY  = 3;

    typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

    function automatic int total_count(input int active, input int fp,
                                       input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/disp_delay_line.sv
// Synchronous-reset shift register; DEPTH=0 degenerates to a wire.
module disp_delay_line
    import disp_timing_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] stage_reg;
                logic [WIDTH-1:0] stage_in;

                if (gi == 0) begin : g_first
                    assign stage_in = d;
                end else begin : g_rest
                    assign stage_in = g_stage[gi-1].stage_reg;
                end

                always_ff @(posedge clk) begin
                    if (srst) begin
                        stage_reg <= RST_VAL;
                    end else begin
                        stage_reg <= stage_in;
                    end
                end
            end
            assign q = g_stage[DEPTH-1].stage_reg;
        end
    endgenerate

endmodule

// File: rtl/disp_timing_gen.sv
// Display timing generator: H/V counters with phase FSMs, registered decodes
// for preDE/VBLANK, and sync outputs delayed to line up with the pixel buffer.
module disp_timing_gen
    import disp_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int OUT_DLY  = DEF_OUT_DLY
) (
    input  logic             DCLK,
    input  logic             DRST,
    input  logic             DISPON,
    output logic             DSP_preDE,
    output logic             DSP_HSYNC,
    output logic             DSP_VSYNC,
    output logic             VBLANK,
    output logic             VBLANK_START,
    output logic [CNT_W-1:0] HCNT,
    output logic [CNT_W-1:0] VCNT
);

    localparam int HTOTAL = total_count(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VTOTAL = total_count(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] V_BLANK_1ST = CNT_W'(V_ACTIVE);
    localparam logic [1:0]       SYNC_IDLE  = {~VS_POL, ~HS_POL};

    generate
        if (HTOTAL > MAX_TOTAL || VTOTAL > MAX_TOTAL) begin : g_bad_total
            $error("disp_timing_gen: HTOTAL/VTOTAL exceed counter range");
        end
    endgenerate

    logic [CNT_W-1:0] hcnt_reg, hcnt_next, vcnt_reg, vcnt_next;
    phase_t           h_phase_reg, h_phase_next, v_phase_reg, v_phase_next;
    logic             disp_en_reg, disp_en_next;
    logic             pre_de_reg, vblank_reg, vblank_start_reg;
    logic [1:0]       sync_raw_reg, sync_raw_next, sync_dly;
    logic             h_wrap, v_wrap;

    assign h_wrap = (hcnt_reg == H_LAST);
    assign v_wrap = (vcnt_reg == V_LAST);

    always_comb begin
        hcnt_next    = h_wrap ? '0 : hcnt_reg + 1'b1;
        vcnt_next    = vcnt_reg;
        disp_en_next = disp_en_reg;
        h_phase_next = h_phase_reg;
        v_phase_next = v_phase_reg;

        if (h_wrap) begin
            vcnt_next = v_wrap ? '0 : vcnt_reg + 1'b1;
        end
        // DISPON is only honoured at the frame boundary so frames are never torn.
        if (h_wrap && v_wrap) begin
            disp_en_next = DISPON;
        end

        case (h_phase_reg)
            ACT:  if (hcnt_reg == H_ACT_END)  h_phase_next = FP;
            FP:   if (hcnt_reg == H_FP_END)   h_phase_next = SYNC;
            SYNC: if (hcnt_reg == H_SYNC_END) h_phase_next = BP;
            BP:   if (h_wrap)                 h_phase_next = ACT;
        endcase

        if (h_wrap) begin
            case (v_phase_reg)
                ACT:  if (vcnt_reg == V_ACT_END)  v_phase_next = FP;
                FP:   if (vcnt_reg == V_FP_END)   v_phase_next = SYNC;
                SYNC: if (vcnt_reg == V_SYNC_END) v_phase_next = BP;
                BP:   if (v_wrap)                 v_phase_next = ACT;
            endcase
        end

        sync_raw_next = {(v_phase_reg == SYNC) ? VS_POL : ~VS_POL,
                         (h_phase_reg == SYNC) ? HS_POL : ~HS_POL};
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            hcnt_reg         <= '0;
            vcnt_reg         <= '0;
            h_phase_reg      <= ACT;
            v_phase_reg      <= ACT;
            disp_en_reg      <= 1'b0;
            pre_de_reg       <= 1'b0;
            vblank_reg       <= 1'b0;
            vblank_start_reg <= 1'b0;
            sync_raw_reg     <= SYNC_IDLE;
        end else begin
            hcnt_reg         <= hcnt_next;
            vcnt_reg         <= vcnt_next;
            h_phase_reg      <= h_phase_next;
            v_phase_reg      <= v_phase_next;
            disp_en_reg      <= disp_en_next;
            pre_de_reg       <= disp_en_reg && (h_phase_reg == ACT) && (v_phase_reg == ACT);
            vblank_reg       <= (v_phase_reg != ACT);
            vblank_start_reg <= (hcnt_reg == '0) && (vcnt_reg == V_BLANK_1ST);
            sync_raw_reg     <= sync_raw_next;
        end
    end

    disp_delay_line #(
        .WIDTH  (2),
        .DEPTH  (OUT_DLY),
        .RST_VAL(SYNC_IDLE)
    ) u_sync_dly (
        .clk (DCLK),
        .srst(DRST),
        .d   (sync_raw_reg),
        .q   (sync_dly)
    );

    assign DSP_preDE    = pre_de_reg;
    assign DSP_HSYNC    = sync_dly[0];
    assign DSP_VSYNC    = sync_dly[1];
    assign VBLANK       = vblank_reg;
    assign VBLANK_START = vblank_start_reg;
    assign HCNT         = hcnt_reg;
    assign VCNT         = vcnt_reg;

endmodule
